// File: rtl/store_commit_buffer.sv
// Store commit buffer: tracks computed stores, signals readiness to the ROB, and
// drains ROB-committed stores to memory one byte per cycle, surviving flushes.
module store_commit_buffer #(
    parameter int SB_SZ     = 8,
    parameter int SB_SZ_LOG = 3,
    parameter int ROB_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_vld,
    input  logic [ROB_TAG_W-1:0] in_rob,
    input  logic [31:0]          in_addr,
    input  logic [31:0]          in_data,
    input  logic [1:0]           in_width,
    output logic                 in_full,
    output logic                 upd_str,
    output logic [ROB_TAG_W-1:0] upd_str_rd,
    input  logic                 commit_str,
    input  logic                 flush,
    input  logic                 mem_gnt,
    output logic                 mem_req,
    output logic                 mem_wr,
    output logic [31:0]          mem_a,
    output logic [7:0]           mem_dout,
    output logic                 busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } drain_state_t;

    localparam logic [SB_SZ_LOG:0]   CNT_FULL = SB_SZ[SB_SZ_LOG:0];
    localparam logic [SB_SZ_LOG:0]   CNT_ONE  = 1;
    localparam logic [SB_SZ_LOG-1:0] PTR_ONE  = 1;

    logic [31:0] ent_addr  [SB_SZ];
    logic [31:0] ent_data  [SB_SZ];
    logic [1:0]  ent_width [SB_SZ];

    logic [SB_SZ_LOG-1:0] head, cmt, tail;
    logic [SB_SZ_LOG-1:0] head_next, cmt_next, tail_next;
    logic [SB_SZ_LOG:0]   count, ncmt;
    logic [SB_SZ_LOG:0]   count_next, ncmt_next;

    drain_state_t state, state_next;
    logic [1:0]   idx, idx_next, last_idx;
    logic         enq, commit_ok, pop;
    logic         wr_next;
    logic [31:0]  a_next;
    logic [7:0]   dout_next;
    logic [31:0]  head_addr, head_data;
    logic [1:0]   head_width;

    // Handshakes: an enqueue is accepted on a cycle with rdy && in_vld && !in_full && !flush;
    // mem_req stays high while committed stores remain, and a byte moves on each rdy && mem_gnt cycle in WRITE.
    assign in_full   = (count == CNT_FULL);
    assign busy      = (count != '0);
    assign mem_req   = (ncmt != '0);
    assign enq       = rdy && in_vld && !in_full && !flush;
    assign commit_ok = rdy && commit_str && (count != ncmt);

    assign head_addr  = ent_addr[head];
    assign head_data  = ent_data[head];
    assign head_width = ent_width[head];

    always_comb begin
        case (head_width)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // Drain FSM: next state and registered memory-port values.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        pop        = 1'b0;
        wr_next    = 1'b0;
        a_next     = mem_a;
        dout_next  = mem_dout;
        if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (ncmt != '0 && mem_gnt) begin
                        state_next = S_WRITE;
                        idx_next   = 2'd0;
                    end
                end
                S_WRITE: begin
                    if (mem_gnt) begin
                        wr_next   = 1'b1;
                        a_next    = head_addr + {30'b0, idx};
                        dout_next = head_data[{idx, 3'b000} +: 8];
                        if (idx == last_idx) begin
                            pop        = 1'b1;
                            state_next = S_IDLE;
                            idx_next   = 2'd0;
                        end else begin
                            idx_next = idx + 2'd1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    idx_next   = 2'd0;
                end
            endcase
        end
    end

    // Pointer and occupancy bookkeeping; a flush rewinds tail to the post-commit boundary.
    always_comb begin
        head_next  = pop ? head + PTR_ONE : head;
        cmt_next   = commit_ok ? cmt + PTR_ONE : cmt;
        ncmt_next  = ncmt;
        count_next = count;
        tail_next  = tail;
        if (commit_ok && !pop) begin
            ncmt_next = ncmt + CNT_ONE;
        end else if (!commit_ok && pop) begin
            ncmt_next = ncmt - CNT_ONE;
        end
        if (flush) begin
            tail_next  = cmt_next;
            count_next = ncmt_next;
        end else begin
            if (enq) begin
                tail_next = tail + PTR_ONE;
            end
            if (enq && !pop) begin
                count_next = count + CNT_ONE;
            end else if (!enq && pop) begin
                count_next = count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail]  <= in_addr;
            ent_data[tail]  <= in_data;
            ent_width[tail] <= in_width;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            cmt   <= '0;
            tail  <= '0;
            count <= '0;
            ncmt  <= '0;
        end else if (rdy) begin
            head  <= head_next;
            cmt   <= cmt_next;
            tail  <= tail_next;
            count <= count_next;
            ncmt  <= ncmt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            mem_wr     <= 1'b0;
            mem_a      <= '0;
            mem_dout   <= '0;
            upd_str    <= 1'b0;
            upd_str_rd <= '0;
        end else if (rdy) begin
            state    <= state_next;
            idx      <= idx_next;
            mem_wr   <= wr_next;
            mem_a    <= a_next;
            mem_dout <= dout_next;
            upd_str  <= enq;
            if (enq) begin
                upd_str_rd <= in_rob;
            end
        end else begin
            mem_wr  <= 1'b0;
            upd_str <= 1'b0;
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: hand-built store sequences, with memory
// writes collected by a monitor and compared against an expected byte queue.
module tb_store_commit_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        in_vld;
    logic [3:0]  in_rob;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_width;
    logic        in_full;
    logic        upd_str;
    logic [3:0]  upd_str_rd;
    logic        commit_str;
    logic        flush;
    logic        mem_gnt;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] exp_q[$];
    logic [39:0] act_q[$];

    store_commit_buffer #(.SB_SZ(8), .SB_SZ_LOG(3), .ROB_TAG_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_vld(in_vld), .in_rob(in_rob), .in_addr(in_addr), .in_data(in_data),
        .in_width(in_width), .in_full(in_full),
        .upd_str(upd_str), .upd_str_rd(upd_str_rd),
        .commit_str(commit_str), .flush(flush),
        .mem_gnt(mem_gnt), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_a(mem_a), .mem_dout(mem_dout), .busy(busy)
    );

    // Clock and reset-time defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Memory-side monitor
    always @(negedge clk) begin
        if (mem_wr === 1'b1) act_q.push_back({mem_a, mem_dout});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: one enqueue cycle, then the ready pulse must appear with this tag.
    task automatic enq_one(input logic [3:0] rob, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] w);
        in_vld = 1'b1; in_rob = rob; in_addr = a; in_data = d; in_width = w;
        step();
        in_vld = 1'b0;
        chk("upd_str", upd_str, 1);
        chk("upd_str_rd", upd_str_rd, rob);
    endtask

    // Expected model: width 0/1/2-3 gives 1/2/4 bytes, LSB first, address wraps mod 2^32.
    task automatic exp_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        int nb;
        nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        for (int b = 0; b < nb; b++) begin
            logic [31:0] ba;
            logic [31:0] sh;
            ba = a + 32'(b);
            sh = d >> (8 * b);
            exp_q.push_back({ba, sh[7:0]});
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            step();
            n++;
        end
        step();
        chk(tag, busy, 0);
    endtask

    task automatic sb_check(input string tag);
        int n;
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; in_vld = 1'b0; in_rob = '0; in_addr = '0; in_data = '0;
        in_width = '0; commit_str = 1'b0; flush = 1'b0; mem_gnt = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_full", in_full, 0);
        chk("rst_upd_str", upd_str, 0);
        chk("rst_upd_rd", upd_str_rd, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_busy", busy, 0);

        // Single word store, commit, four consecutive byte writes
        enq_one(4'd3, 32'h0000_1000, 32'hAABB_CCDD, 2'd2);
        exp_store(32'h0000_1000, 32'hAABB_CCDD, 2'd2);
        chk("w_busy", busy, 1);
        chk("w_req_before_commit", mem_req, 0);
        commit_str = 1'b1; mem_gnt = 1'b1;
        step();
        commit_str = 1'b0;
        chk("w_upd_one_cycle", upd_str, 0);
        chk("w_req", mem_req, 1);
        step();
        chk("w_idle_cycle", mem_wr, 0);
        step(); chk("w_wr0", mem_wr, 1); chk("w_a0", mem_a, 32'h1000); chk("w_d0", mem_dout, 8'hDD);
        step(); chk("w_wr1", mem_wr, 1); chk("w_a1", mem_a, 32'h1001); chk("w_d1", mem_dout, 8'hCC);
        step(); chk("w_wr2", mem_wr, 1); chk("w_a2", mem_a, 32'h1002); chk("w_d2", mem_dout, 8'hBB);
        step(); chk("w_wr3", mem_wr, 1); chk("w_a3", mem_a, 32'h1003); chk("w_d3", mem_dout, 8'hAA);
        chk("w_busy_after", busy, 0);
        chk("w_req_after", mem_req, 0);
        step();
        chk("w_wr_done", mem_wr, 0);
        sb_check("word");

        // Fill to full, reject a 9th, then commit and drain with a wrapping half-word
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a, d;
            logic [1:0] w;
            a = (k == 3) ? 32'hFFFF_FFFF : 32'h2000 + 32'(16 * k);
            d = 32'h1020_3040 + 32'(k) * 32'h0101_0101;
            w = (k == 3) ? 2'd1 : (k == 7) ? 2'd2 : 2'd0;
            enq_one(4'(k + 1), a, d, w);
            exp_store(a, d, w);
        end
        chk("fill_full", in_full, 1);
        chk("fill_no_drain", mem_req, 0);
        in_vld = 1'b1; in_rob = 4'd9; in_addr = 32'h9999_0000; in_data = 32'h99; in_width = 2'd0;
        step();
        in_vld = 1'b0;
        chk("full_no_upd", upd_str, 0);
        chk("full_hold", in_full, 1);
        commit_str = 1'b1;
        repeat (8) step();
        commit_str = 1'b0;
        wait_idle("fill1_idle", 300);
        sb_check("fill1");

        // Second fill wraps all pointers again
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a, d;
            logic [1:0] w;
            a = 32'h3000 + 32'(8 * k);
            d = 32'hDEAD_0000 | (32'(k) * 32'h111);
            w = 2'(k % 3);
            enq_one(4'(k + 8), a, d, w);
            exp_store(a, d, w);
        end
        chk("fill2_full", in_full, 1);
        commit_str = 1'b1;
        repeat (8) step();
        commit_str = 1'b0;
        wait_idle("fill2_idle", 300);
        sb_check("fill2");

        // Flush together with a second commit; same-cycle enqueue dropped
        mem_gnt = 1'b0;
        enq_one(4'd1, 32'h6000, 32'h0000_00E1, 2'd0);
        enq_one(4'd2, 32'h6010, 32'h0000_B2B1, 2'd1);
        enq_one(4'd3, 32'h6020, 32'hC4C3_C2C1, 2'd2);
        exp_store(32'h6000, 32'h0000_00E1, 2'd0);
        exp_store(32'h6010, 32'h0000_B2B1, 2'd1);
        commit_str = 1'b1;
        step();
        flush = 1'b1; in_vld = 1'b1; in_rob = 4'd4; in_addr = 32'h6030; in_data = 32'hD1; in_width = 2'd0;
        step();
        flush = 1'b0; in_vld = 1'b0; commit_str = 1'b0;
        chk("flush_no_upd", upd_str, 0);
        chk("flush_busy", busy, 1);
        chk("flush_req", mem_req, 1);
        mem_gnt = 1'b1;
        wait_idle("flush_idle", 100);
        sb_check("flush");
        chk("flush_not_full", in_full, 0);

        // Byte drain with grant toggling and a two-cycle rdy stall
        mem_gnt = 1'b0;
        enq_one(4'd5, 32'h4000, 32'h0000_005A, 2'd0);
        exp_store(32'h4000, 32'h0000_005A, 2'd0);
        commit_str = 1'b1;
        step();
        commit_str = 1'b0;
        chk("st_req", mem_req, 1);
        mem_gnt = 1'b1; step(); chk("st_wr_c1", mem_wr, 0);
        mem_gnt = 1'b0; step(); chk("st_wr_c2", mem_wr, 0);
        step(); chk("st_wr_c3", mem_wr, 0);
        mem_gnt = 1'b1; rdy = 1'b0;
        step(); chk("st_wr_c4", mem_wr, 0); chk("st_busy_c4", busy, 1); chk("st_req_c4", mem_req, 1);
        step(); chk("st_wr_c5", mem_wr, 0);
        rdy = 1'b1;
        step(); chk("st_wr_c6", mem_wr, 1); chk("st_a_c6", mem_a, 32'h4000); chk("st_d_c6", mem_dout, 8'h5A);
        chk("st_busy_c6", busy, 0);
        mem_gnt = 1'b0; rdy = 1'b0;
        step(); chk("st_wr_c7", mem_wr, 0); chk("st_a_hold", mem_a, 32'h4000); chk("st_d_hold", mem_dout, 8'h5A);
        rdy = 1'b1;
        step();
        sb_check("stall");

        // Commit on empty buffer is ignored
        commit_str = 1'b1; mem_gnt = 1'b1;
        step();
        commit_str = 1'b0;
        chk("ec_req", mem_req, 0);
        enq_one(4'd6, 32'h5000, 32'h0000_0077, 2'd0);
        repeat (4) step();
        chk("ec_req_uncommitted", mem_req, 0);
        chk("ec_busy", busy, 1);
        chk("ec_no_write", act_q.size(), 0);
        exp_store(32'h5000, 32'h0000_0077, 2'd0);
        commit_str = 1'b1;
        step();
        commit_str = 1'b0;
        wait_idle("ec_idle", 50);
        sb_check("empty_commit");

        // Reset in the middle of a word drain
        enq_one(4'd7, 32'h7000, 32'h89AB_CDEF, 2'd2);
        commit_str = 1'b1;
        step();
        commit_str = 1'b0;
        begin
            int n;
            n = 0;
            while (mem_wr !== 1'b1 && n < 10) begin
                step();
                n++;
            end
        end
        chk("mr_first_byte", mem_a, 32'h7000);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_in_full", in_full, 0);
        chk("mr_upd_str", upd_str, 0);
        chk("mr_mem_req", mem_req, 0);
        chk("mr_mem_wr", mem_wr, 0);
        chk("mr_mem_a", mem_a, 0);
        chk("mr_mem_dout", mem_dout, 0);
        chk("mr_busy", busy, 0);
        step();
        rst = 1'b0;
        act_q.delete();
        exp_q.delete();
        repeat (6) step();
        chk("mr_no_more_wr", act_q.size(), 0);
        chk("mr_busy_after", busy, 0);
        chk("mr_req_after", mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Commit-side consumer of the ROB store protocol.
- Holds computed stores tagged with their ROB index and reports each one ready to the ROB with a `run_upd_str`-style pulse.
- On each in-order store-commit pulse from the ROB, marks the oldest uncommitted store as committed, then drains committed stores to memory one byte per cycle.
- On a mispredict flush, discards uncommitted stores and keeps draining committed ones.

Parameters:
- SB_SZ, 8: entry count; power of two.
- SB_SZ_LOG, 3: log2(SB_SZ).
- ROB_TAG_W, 4: ROB tag width; tags start from 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  pause when low
- in_vld  in  1  store operands computed, enqueue request
- in_rob  in  ROB_TAG_W  ROB tag of the store
- in_addr  in  32  byte address
- in_data  in  32  store data, LSB first
- in_width  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- in_full  out  1  buffer full; enqueue ignored
- upd_str  out  1  pulse: store ready, to the ROB
- upd_str_rd  out  ROB_TAG_W  tag for upd_str
- commit_str  in  1  ROB commits the oldest uncommitted store
- flush  in  1  ROB jump/branch reset
- mem_gnt  in  1  memory port granted this cycle
- mem_req  out  1  committed store pending
- mem_wr  out  1  byte write strobe
- mem_a  out  32  byte address
- mem_dout  out  8  byte data
- busy  out  1  buffer non-empty

Behaviour:
- State: circular entries with pointers head (drain), cmt (first uncommitted), tail (next free), plus count 0..SB_SZ and ncmt 0..SB_SZ (committed, not yet popped). Pointers wrap SB_SZ-1 -> 0.
- Async reset: pointers 0, counts 0, FSM IDLE, byte index 0. in_full, upd_str, upd_str_rd, mem_req, mem_wr, mem_a, mem_dout, busy all 0.
- rdy low: all state frozen; mem_wr is 0 that cycle; upd_str is 0.
- Enqueue: in_vld && !in_full && !flush writes the entry at tail and increments tail and count. On the next edge, upd_str=1 and upd_str_rd=in_rob for exactly one cycle. Otherwise upd_str=0.
- in_full = (count==SB_SZ), combinational. When full, in_vld is ignored and no upd_str is issued.
- Commit: commit_str with (count-ncmt)>0 advances cmt and increments ncmt. commit_str with no uncommitted entry is ignored.
- Flush:
  - Applied after that cycle's commit, so a same-cycle commit_str is honoured first.
  - tail <= cmt (post-commit), count <= ncmt (post-commit, less any same-cycle pop).
  - The same-cycle enqueue is dropped; upd_str is 0 next cycle.
  - In-progress drain continues untouched.
- Drain FSM:
  - IDLE: mem_req = (ncmt>0). If ncmt>0 && mem_gnt: byte index i<=0, go WRITE.
  - WRITE, with mem_gnt:
    - mem_wr<=1, mem_a<=addr+i (mod 2^32), mem_dout<=data[8i+7:8i].
    - If i = nbytes-1 (nbytes = 1/2/4 per width): pop head, decrement count and ncmt, go IDLE.
    - Else i<=i+1.
  - WRITE, mem_gnt low: mem_wr<=0, state held.
  - mem_wr is registered and high one cycle per byte. Minimum store latency is 1 cycle in IDLE, then nbytes write cycles; there is one IDLE cycle between stores.
- Simultaneous enqueue+pop: count unchanged. Simultaneous commit+pop: ncmt unchanged.
- busy = (count!=0). The ROB may flush any time; committed data is never lost.

Test Plan:
- Reset mid-drain: assert rst during the WRITE of a word -> next cycle all outputs 0, busy=0, no further mem_wr.
- Enqueue {rob=3, addr=0x1000, data=0xAABBCCDD, width=2}, then commit_str, mem_gnt=1 -> upd_str=1, rd=3 one cycle after enqueue; writes (0x1000,DD), (0x1001,CC), (0x1002,BB), (0x1003,AA) on consecutive cycles; busy drops after pop.
- Fill 8 stores without commit -> in_full=1; a 9th in_vld gives no upd_str and count stays 8. Commit and drain all 8 with a half-word at addr 0xFFFFFFFF -> second byte goes to 0x00000000. Pointers wrap correctly on the next fill.
- Enqueue 3 stores, commit 1, flush in the same cycle as a 2nd commit_str -> exactly 2 stores written to memory, count=0 afterwards, no upd_str for an enqueue attempted in the flush cycle.
- Drain byte store with mem_gnt toggling 1,0,0,1 and rdy low for 2 cycles -> mem_wr high only on granted, rdy-high cycles; address and data unchanged across stalls.
- commit_str with an empty buffer -> ignored, ncmt stays 0, and a later enqueued store is not written until its own commit.
